// File: rtl/data_mem_resp_if.sv
// Request/response bus between an initiator and the data_mem_resp memory model.
interface data_mem_resp_if;
  logic        req_valid;
  logic        req_ready;
  logic        MemRead;
  logic        MemWrite;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] rdata;
  logic        resp_err;

  modport master (
    output req_valid, MemRead, MemWrite, addr, wdata, resp_ready,
    input  req_ready, resp_valid, rdata, resp_err
  );

  modport slave (
    input  req_valid, MemRead, MemWrite, addr, wdata, resp_ready,
    output req_ready, resp_valid, rdata, resp_err
  );
endinterface

// File: rtl/data_mem_resp.sv
// Word-addressed 64-bit data memory with fixed wait-state latency and a held response.
// Optional feature: define DMEM_ALIGN_CHECK_EN to reject addresses with addr[2:0] != 0.
module data_mem_resp #(
  parameter int unsigned DEPTH_LOG2  = 5,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  data_mem_resp_if.slave bus
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic [63:0]           mem [DEPTH];

  logic [DEPTH_LOG2-1:0] lat_idx, cur_idx, in_idx;
  logic [63:0]           lat_wdata, cur_wdata;
  logic                  lat_rd, lat_wr, lat_mis;
  logic                  cur_rd, cur_wr, cur_mis, in_mis;
  logic                  accept, enter_resp, cur_err, mem_we;
  logic                  req_ready_q, resp_valid_q, resp_err_q;
  logic [63:0]           rdata_q;
  logic                  addr_unused;

  assign in_idx = bus.addr[DEPTH_LOG2+2:3];
`ifdef DMEM_ALIGN_CHECK_EN
  assign in_mis = |bus.addr[2:0];
`else
  assign in_mis = 1'b0;
`endif
  assign addr_unused = ^{bus.addr[63:DEPTH_LOG2+3], bus.addr[2:0]};

  assign accept = (state == IDLE) && bus.req_valid && (bus.MemRead || bus.MemWrite);

  // With zero wait states the response is formed from the live inputs on the
  // acceptance edge; otherwise from the copy latched at acceptance.
  always_comb begin
    cur_idx   = lat_idx;
    cur_wdata = lat_wdata;
    cur_rd    = lat_rd;
    cur_wr    = lat_wr;
    cur_mis   = lat_mis;
    if (state == IDLE) begin
      cur_idx   = in_idx;
      cur_wdata = bus.wdata;
      cur_rd    = bus.MemRead;
      cur_wr    = bus.MemWrite;
      cur_mis   = in_mis;
    end
  end

  assign enter_resp = (accept && (WAIT_CYCLES == 0)) || ((state == WAIT) && (cnt == 4'd1));
  assign cur_err    = (cur_rd && cur_wr) || cur_mis;
  assign mem_we     = rst_n && enter_resp && cur_wr && !cur_err;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[cur_idx] <= cur_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rdata_q      <= '0;
      lat_idx      <= '0;
      lat_wdata    <= '0;
      lat_rd       <= 1'b0;
      lat_wr       <= 1'b0;
      lat_mis      <= 1'b0;
    end else begin
      if (enter_resp) begin
        resp_valid_q <= 1'b1;
        resp_err_q   <= cur_err;
        rdata_q      <= (cur_rd && !cur_err) ? mem[cur_idx] : '0;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            lat_idx     <= in_idx;
            lat_wdata   <= bus.wdata;
            lat_rd      <= bus.MemRead;
            lat_wr      <= bus.MemWrite;
            lat_mis     <= in_mis;
            req_ready_q <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= 4'(WAIT_CYCLES);
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            state        <= IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.rdata      = rdata_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed and random transactions against a word-array reference model of data_mem_resp.
module tb_data_mem_resp;

  localparam int unsigned DL    = 5;
  localparam int unsigned WC    = 2;
  localparam int unsigned DEPTH = 1 << DL;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  data_mem_resp_if bus ();

  data_mem_resp #(.DEPTH_LOG2(DL), .WAIT_CYCLES(WC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [63:0] model [DEPTH];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned widx(input logic [63:0] a);
    logic [63:0] t;
    t = (a / 64'd8) % 64'(DEPTH);
    return 32'(t);
  endfunction

  task automatic scramble();
    bus.req_valid = 1'($urandom);
    bus.MemRead   = 1'($urandom);
    bus.MemWrite  = 1'($urandom);
    bus.addr      = {$urandom, $urandom};
    bus.wdata     = {$urandom, $urandom};
  endtask

  task automatic txn(input logic rd, input logic wr, input logic [63:0] a,
                     input logic [63:0] wd, input int unsigned hold);
    logic        err;
    logic [63:0] er;
    logic [2:0]  lo;
    int unsigned lat;
    lo  = a[2:0];
    err = (rd && wr) || (ALIGN && (lo != 3'd0));
    er  = (rd && !err) ? model[widx(a)] : 64'd0;
    if (wr && !err) model[widx(a)] = wd;

    @(negedge clk);
    check("req_ready_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.MemRead   = rd;
    bus.MemWrite  = wr;
    bus.addr      = a;
    bus.wdata     = wd;
    @(posedge clk);
    #1 scramble();
    lat = 1;
    @(negedge clk);
    while (!bus.resp_valid && lat < 40) begin
      scramble();
      @(negedge clk);
      lat++;
    end
    check("latency", lat, WC + 1);
    check("rdata", bus.rdata, er);
    check("resp_err", bus.resp_err, err);
    check("req_ready_busy", bus.req_ready, 0);
    for (int i = 0; i < hold; i++) begin
      scramble();
      @(negedge clk);
      check("resp_valid_hold", bus.resp_valid, 1);
      check("rdata_hold", bus.rdata, er);
      check("resp_err_hold", bus.resp_err, err);
      check("req_ready_hold", bus.req_ready, 0);
    end
    // A live load request on the handshake edge must not be taken.
    bus.resp_ready = 1'b1;
    bus.req_valid  = 1'b1;
    bus.MemRead    = 1'b1;
    bus.MemWrite   = 1'b0;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b0;
    check("resp_valid_drop", bus.resp_valid, 0);
    check("req_ready_back", bus.req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a, wd;
    int unsigned op, n;

    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.MemRead    = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.addr       = '0;
    bus.wdata      = '0;
    bus.resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_resp_err", bus.resp_err, 0);
    rst_n = 1'b1;

    for (int i = 0; i < DEPTH; i++) txn(1'b0, 1'b1, 64'(i * 8), {$urandom, $urandom}, 0);

    txn(1'b0, 1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, 0);
    txn(1'b1, 1'b0, 64'h10, 64'h0, 0);
    check("model_0x10", model[2], 64'hDEADBEEF_CAFEF00D);

    txn(1'b0, 1'b1, 64'h100, 64'h1, 0);
    txn(1'b1, 1'b0, 64'h0, 64'h0, 0);
    check("model_wrap", model[0], 64'h1);

    txn(1'b1, 1'b0, 64'h28, 64'h0, 5);

    txn(1'b1, 1'b1, 64'h8, 64'h55, 0);
    txn(1'b1, 1'b0, 64'h8, 64'h0, 0);

    // Reset during the wait states of a store: no commit, outputs reset at once.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b1;
    bus.addr      = 64'h18;
    bus.wdata     = 64'hAA;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_req_ready", bus.req_ready, 1);
    check("async_rst_resp_valid", bus.resp_valid, 0);
    check("async_rst_rdata", bus.rdata, 0);
    check("async_rst_resp_err", bus.resp_err, 0);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    txn(1'b1, 1'b0, 64'h18, 64'h0, 0);

    // Reset while a load response is being held.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.MemRead   = 1'b1;
    bus.MemWrite  = 1'b0;
    bus.addr      = 64'h10;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus.resp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("resp_rdata_pre_rst", bus.rdata, model[2]);
    rst_n = 1'b0;
    #1;
    check("resp_rst_rdata", bus.rdata, 0);
    check("resp_rst_resp_valid", bus.resp_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    txn(1'b1, 1'b0, 64'h13, 64'h0, 0);

    // Requests with neither MemRead nor MemWrite are ignored.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("noop_req_ready", bus.req_ready, 1);
      check("noop_resp_valid", bus.resp_valid, 0);
    end
    bus.req_valid = 1'b0;

    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 2);
      a  = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0) a[2:0] = 3'd0;
      wd = {$urandom, $urandom};
      txn(op != 1, op != 0, a, wd, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 5, setting the storage to 2**DEPTH_LOG2 64-bit words.
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, giving the wait states between acceptance and response (0..15).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port req_valid, input, 1 bit: the initiator presents a request.
REQ-006 The block SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-007 The block SHALL have port MemRead, input, 1 bit: the request is a load.
REQ-008 The block SHALL have port MemWrite, input, 1 bit: the request is a store.
REQ-009 The block SHALL have port addr, input, 64 bits: byte address.
REQ-010 The block SHALL have port wdata, input, 64 bits: store data.
REQ-011 The block SHALL have port resp_valid, output, 1 bit: the response is available.
REQ-012 The block SHALL have port resp_ready, input, 1 bit: the initiator takes the response.
REQ-013 The block SHALL have port rdata, output, 64 bits: load data.
REQ-014 The block SHALL have port resp_err, output, 1 bit: the request was rejected and performed no access.

Function
REQ-015 The FSM SHALL have the states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 A request SHALL be accepted on a rising edge with req_valid=1 and state IDLE; at acceptance addr, wdata, MemRead and MemWrite SHALL be latched.
REQ-017 A cycle in IDLE with req_valid=1 and MemRead=MemWrite=0 SHALL be ignored: no acceptance and state stays IDLE.
REQ-018 On acceptance the FSM SHALL go to WAIT with a counter loaded to WAIT_CYCLES, or go directly to RESP when WAIT_CYCLES=0.
REQ-019 In WAIT the counter SHALL decrement each cycle; the FSM SHALL go to RESP on the edge where the counter equals 1.
REQ-020 Response latency SHALL be exactly WAIT_CYCLES+1 cycles from the acceptance edge to the first cycle with resp_valid=1.
REQ-021 The word index SHALL be addr[DEPTH_LOG2+2:3]; higher address bits SHALL be ignored, so addresses wrap modulo the storage size.
REQ-022 A store SHALL update the storage on the edge entering RESP; in that response rdata SHALL be 0.
REQ-023 A load SHALL capture storage[index] into rdata on the edge entering RESP.
REQ-024 A load issued immediately after a store to the same index SHALL return the new data.
REQ-025 resp_valid, rdata and resp_err SHALL be held stable in RESP until resp_ready=1.
REQ-026 On the edge where resp_valid=1 and resp_ready=1 the FSM SHALL return to IDLE, with resp_valid=0 in the next cycle.
REQ-027 A new request SHALL not be accepted on the same edge as the response handshake; the minimum spacing between acceptances is WAIT_CYCLES+2 cycles.
REQ-028 An accepted request with MemRead=MemWrite=1 SHALL produce resp_err=1 and rdata=0, with storage unchanged.
REQ-029 Input changes outside the acceptance edge SHALL have no effect on an in-flight request.

Reset
REQ-030 While rst_n=0 the block SHALL hold state IDLE, counter 0, req_ready=1, resp_valid=0, rdata=0 and resp_err=0.
REQ-031 Reset asserted mid-operation, in WAIT or RESP, SHALL abort the request; a store not yet committed SHALL NOT be written.
REQ-032 The storage contents SHALL NOT be reset.

Configuration
REQ-033 With macro DMEM_ALIGN_CHECK_EN defined, an accepted request with addr[2:0] != 0 SHALL respond with resp_err=1 and rdata=0, with no storage access and unchanged latency.
REQ-034 With DMEM_ALIGN_CHECK_EN undefined, addr[2:0] SHALL be ignored and misaligned requests SHALL access the word at the index, with resp_err=0.

Verification
REQ-035 WAIT_CYCLES=2: store 0xDEADBEEF_CAFEF00D at addr 0x10, then load 0x10 -> load resp_valid 3 cycles after acceptance with rdata=0xDEADBEEF_CAFEF00D and resp_err=0.
REQ-036 DEPTH_LOG2=5: store 0x1 at addr 0x100, then load addr 0x0 -> rdata=0x1 (wrap-around).
REQ-037 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid and rdata stable for all 5 cycles; req_ready=0 throughout.
REQ-038 MemRead=MemWrite=1 at addr 0x8 with wdata 0x55 -> resp_err=1 and rdata=0; a subsequent load of 0x8 returns the prior contents.
REQ-039 Drop rst_n in WAIT of a store of 0xAA to 0x18 -> outputs go to reset values immediately; a later load of 0x18 returns the pre-store value.
REQ-040 Load addr 0x13 -> resp_err=1 with DMEM_ALIGN_CHECK_EN defined; rdata=storage[2] and resp_err=0 without it.
